// File: rtl/uart_retrans_tx.sv
// uart_retrans_tx: even-parity UART transmitter with ack/resend handshake.
// Sends a 7-bit word as a 10-bit frame (start 0, data LSB first, even
// parity, stop 1). It then waits for the receiver's ack. On request_resend,
// or when no answer arrives within TIMEOUT cycles, it resends the latched
// frame, up to MAX_RESEND times.
// Optional build macro: UART_TX_ERR_INJECT_EN adds the inject_err input. When
// the latched inject_err is 1, the first transmission of that word carries an
// inverted parity bit.
module uart_retrans_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int TIMEOUT      = 10,
    parameter int MAX_RESEND   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] data,
`ifdef UART_TX_ERR_INJECT_EN
    input  logic       inject_err,
`endif
    input  logic       ack,
    input  logic       request_resend,
    output logic       signal,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [4:0] resend_count
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_ACK} state_t;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [4:0]    RESEND_MAX = 5'(MAX_RESEND);

    state_t          state_reg,   state_next;
    logic [CW-1:0]   clk_cnt_reg, clk_cnt_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [TW-1:0]   to_cnt_reg,  to_cnt_next;
    logic [6:0]      word_reg,    word_next;
    logic            parity_reg,  parity_next;
    logic            inj_reg,     inj_next;
    logic [4:0]      resend_reg,  resend_next;
    logic            signal_reg,  signal_next;
    logic            done_reg,    done_next;
    logic            fail_reg,    fail_next;
    logic            inject_in;
    logic            bit_end;

`ifdef UART_TX_ERR_INJECT_EN
    assign inject_in = inject_err;
`else
    assign inject_in = 1'b0;
`endif

    assign bit_end = (clk_cnt_reg == BIT_LAST);

    // State and datapath registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            to_cnt_reg  <= '0;
            word_reg    <= '0;
            parity_reg  <= 1'b0;
            inj_reg     <= 1'b0;
            resend_reg  <= '0;
            signal_reg  <= 1'b1;
            done_reg    <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
            to_cnt_reg  <= to_cnt_next;
            word_reg    <= word_next;
            parity_reg  <= parity_next;
            inj_reg     <= inj_next;
            resend_reg  <= resend_next;
            signal_reg  <= signal_next;
            done_reg    <= done_next;
            fail_reg    <= fail_next;
        end
    end

    // Next-state logic. The serial line is decoded from the next state so that it leaves a register.
    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_idx_next = bit_idx_reg;
        to_cnt_next  = to_cnt_reg;
        word_next    = word_reg;
        parity_next  = parity_reg;
        inj_next     = inj_reg;
        resend_next  = resend_reg;
        done_next    = 1'b0;
        fail_next    = 1'b0;
        signal_next  = 1'b1;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    word_next    = data;
                    parity_next  = ^data;
                    inj_next     = inject_in;
                    resend_next  = '0;
                    clk_cnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    if (bit_idx_reg == 3'd6) begin
                        state_next = PARITY;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    state_next   = STOP;
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    to_cnt_next  = '0;
                    state_next   = WAIT_ACK;
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            WAIT_ACK: begin
                to_cnt_next = to_cnt_reg + TW'(1);
                // ack has priority. A timeout coinciding with a resend request counts once.
                if (ack) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (request_resend || (to_cnt_reg == TO_LAST)) begin
                    if (resend_reg < RESEND_MAX) begin
                        resend_next  = resend_reg + 5'd1;
                        clk_cnt_next = '0;
                        state_next   = START;
                    end else begin
                        fail_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   signal_next = 1'b0;
            DATA:    signal_next = word_next[bit_idx_next];
            // An injected error only affects the first transmission (resend count still zero).
            PARITY:  signal_next = parity_next ^ (inj_next && (resend_next == 5'd0));
            default: signal_next = 1'b1;
        endcase
    end

    assign signal       = signal_reg;
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;
    assign fail         = fail_reg;
    assign resend_count = resend_reg;

endmodule
